// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit. Every operation takes a fixed 33 edges
// from acceptance to the DONE cycle: 32 shift-add / restoring-divide steps on magnitudes, then one sign-fix edge.
module muldiv_unit (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  funct3,
    input  logic [31:0] operand_a,
    input  logic [31:0] operand_b,
    input  logic [4:0]  rd_in,
    output logic        busy,
    output logic        done,
    output logic [31:0] result,
    output logic [4:0]  rd_out,
    output logic        regwrite,
    output logic [1:0]  state_dbg
);
    typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

    state_t      state;
    logic [5:0]  count;
    logic [63:0] acc;       // product, or {remainder, quotient} while dividing
    logic [31:0] m;         // multiplicand magnitude, or divisor magnitude
    logic [31:0] a_raw;
    logic [2:0]  op;
    logic [4:0]  rd_q;
    logic        neg_q, neg_r, div_zero;

    logic        a_neg, b_neg;
    logic [31:0] mag_a, mag_b;
    logic [32:0] mul_sum, div_diff;
    logic [63:0] mul_next, div_next, prod;
    logic [31:0] quot, rem, final_res;

    // Handshake: start is a request taken only on an edge where busy=0; busy
    // stays high from that edge through the done cycle, so requests made
    // while busy are dropped rather than queued.
    assign busy      = (state != IDLE);
    assign state_dbg = state;

    always_comb begin
        a_neg = 1'b0;
        b_neg = 1'b0;
        case (funct3)
            3'b001, 3'b100, 3'b110: begin
                a_neg = operand_a[31];
                b_neg = operand_b[31];
            end
            3'b010:  a_neg = operand_a[31];
            default: ;
        endcase
        mag_a = a_neg ? (~operand_a + 32'd1) : operand_a;
        mag_b = b_neg ? (~operand_b + 32'd1) : operand_b;
    end

    always_comb begin
        mul_sum  = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, m} : 33'd0);
        mul_next = {mul_sum, acc[31:1]};
        div_diff = acc[63:31] - {1'b0, m};
        div_next = div_diff[32] ? {acc[62:0], 1'b0}
                                : {div_diff[31:0], acc[30:0], 1'b1};
    end

    always_comb begin
        prod = neg_q ? (~acc + 64'd1) : acc;
        quot = neg_q ? (~acc[31:0] + 32'd1) : acc[31:0];
        rem  = neg_r ? (~acc[63:32] + 32'd1) : acc[63:32];
        case (op)
            3'b000:                 final_res = prod[31:0];
            3'b001, 3'b010, 3'b011: final_res = prod[63:32];
            3'b100, 3'b101:         final_res = div_zero ? 32'hFFFF_FFFF : quot;
            default:                final_res = div_zero ? a_raw : rem;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= IDLE;
            count    <= 6'd0;
            acc      <= 64'd0;
            m        <= 32'd0;
            a_raw    <= 32'd0;
            op       <= 3'd0;
            rd_q     <= 5'd0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            div_zero <= 1'b0;
            done     <= 1'b0;
            regwrite <= 1'b0;
            result   <= 32'd0;
            rd_out   <= 5'd0;
        end else begin
            case (state)
                IDLE: begin
                    done     <= 1'b0;
                    regwrite <= 1'b0;
                    if (start) begin
                        op       <= funct3;
                        rd_q     <= rd_in;
                        a_raw    <= operand_a;
                        count    <= 6'd0;
                        neg_q    <= a_neg ^ b_neg;
                        neg_r    <= a_neg;
                        div_zero <= (operand_b == 32'd0);
                        acc      <= {32'd0, funct3[2] ? mag_a : mag_b};
                        m        <= funct3[2] ? mag_b : mag_a;
                        state    <= BUSY;
                    end
                end
                BUSY: begin
                    if (count == 6'd32) begin
                        result   <= final_res;
                        rd_out   <= rd_q;
                        done     <= 1'b1;
                        regwrite <= (rd_q != 5'd0);
                        state    <= DONE;
                    end else begin
                        acc   <= op[2] ? div_next : mul_next;
                        count <= count + 6'd1;
                    end
                end
                DONE: begin
                    done     <= 1'b0;
                    regwrite <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: vector table of RV32M ops with hand-computed
// results, plus sequences for ignored start, rd=0 and mid-operation reset.
module tb_muldiv_unit;
    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  funct3;
    logic [31:0] operand_a, operand_b;
    logic [4:0]  rd_in;
    logic        busy, done, regwrite;
    logic [31:0] result;
    logic [4:0]  rd_out;
    logic [1:0]  state_dbg;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [2:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[19];

    muldiv_unit dut (
        .clock(clock), .reset(reset), .start(start), .funct3(funct3),
        .operand_a(operand_a), .operand_b(operand_b), .rd_in(rd_in),
        .busy(busy), .done(done), .result(result), .rd_out(rd_out),
        .regwrite(regwrite), .state_dbg(state_dbg)
    );

    initial forever #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Issue one op, wait (bounded) for done, check latency and outputs.
    task automatic run_op(input string name, input logic [2:0] f, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] rd, input logic [31:0] exp);
        int n;
        @(negedge clock);
        start = 1'b1; funct3 = f; operand_a = a; operand_b = b; rd_in = rd;
        @(posedge clock); #1;
        start = 1'b0;
        check({name, " busy_after_start"}, {31'd0, busy}, 32'd1);
        n = 0;
        while (!done && n < 40) begin
            @(posedge clock); #1;
            n++;
        end
        check({name, " latency"}, n, 32'd33);
        check({name, " result"}, result, exp);
        check({name, " rd_out"}, {27'd0, rd_out}, {27'd0, rd});
        check({name, " regwrite"}, {31'd0, regwrite}, {31'd0, rd != 5'd0});
        @(posedge clock); #1;
        check({name, " done_one_cycle"}, {31'd0, done}, 32'd0);
        check({name, " idle_after"}, {31'd0, busy}, 32'd0);
        check({name, " result_hold"}, result, exp);
    endtask

    initial begin
        vecs[0]  = '{3'b000, 32'd7,          32'hFFFF_FFFD, 5'd5,  32'hFFFF_FFEB};
        vecs[1]  = '{3'b001, 32'h8000_0000,  32'h8000_0000, 5'd1,  32'h4000_0000};
        vecs[2]  = '{3'b010, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd2,  32'hFFFF_FFFF};
        vecs[3]  = '{3'b011, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd3,  32'hFFFF_FFFE};
        vecs[4]  = '{3'b100, 32'hFFFF_FFF9,  32'd2,         5'd4,  32'hFFFF_FFFD};
        vecs[5]  = '{3'b110, 32'hFFFF_FFF9,  32'd2,         5'd6,  32'hFFFF_FFFF};
        vecs[6]  = '{3'b101, 32'd100,        32'd7,         5'd7,  32'd14};
        vecs[7]  = '{3'b111, 32'd100,        32'd7,         5'd8,  32'd2};
        vecs[8]  = '{3'b100, 32'd5,          32'd0,         5'd9,  32'hFFFF_FFFF};
        vecs[9]  = '{3'b110, 32'd5,          32'd0,         5'd10, 32'd5};
        vecs[10] = '{3'b100, 32'h8000_0000,  32'hFFFF_FFFF, 5'd11, 32'h8000_0000};
        vecs[11] = '{3'b110, 32'h8000_0000,  32'hFFFF_FFFF, 5'd12, 32'd0};
        vecs[12] = '{3'b101, 32'd5,          32'd0,         5'd13, 32'hFFFF_FFFF};
        vecs[13] = '{3'b111, 32'd5,          32'd0,         5'd14, 32'd5};
        vecs[14] = '{3'b100, 32'hFFFF_FFF9,  32'd0,         5'd15, 32'hFFFF_FFFF};
        vecs[15] = '{3'b110, 32'hFFFF_FFF9,  32'd0,         5'd16, 32'hFFFF_FFF9};
        vecs[16] = '{3'b001, 32'hFFFF_FFFD,  32'd7,         5'd17, 32'hFFFF_FFFF};
        vecs[17] = '{3'b100, 32'd7,          32'hFFFF_FFFE, 5'd18, 32'hFFFF_FFFD};
        vecs[18] = '{3'b110, 32'd7,          32'hFFFF_FFFE, 5'd31, 32'd1};

        reset = 1'b1; start = 1'b1; funct3 = 3'd0;
        operand_a = 32'd1; operand_b = 32'd1; rd_in = 5'd1;
        repeat (3) @(posedge clock);
        #1;
        check("reset busy", {31'd0, busy}, 32'd0);
        check("reset done", {31'd0, done}, 32'd0);
        check("reset regwrite", {31'd0, regwrite}, 32'd0);
        check("reset result", result, 32'd0);
        check("reset rd_out", {27'd0, rd_out}, 32'd0);
        check("reset state", {30'd0, state_dbg}, 32'd0);
        @(negedge clock);
        reset = 1'b0; start = 1'b0;

        for (int i = 0; i < 19; i++)
            run_op($sformatf("vec%0d", i), vecs[i].f, vecs[i].a, vecs[i].b, vecs[i].rd, vecs[i].exp);

        // Start while busy is ignored; rd_in=0 completes without regwrite.
        begin
            int n;
            @(negedge clock);
            start = 1'b1; funct3 = 3'b000; operand_a = 32'd6; operand_b = 32'd9; rd_in = 5'd0;
            @(posedge clock); #1;
            start = 1'b0;
            n = 0;
            repeat (9) begin @(posedge clock); #1; n++; end
            @(negedge clock);
            start = 1'b1; funct3 = 3'b101; operand_a = 32'd1000; operand_b = 32'd3; rd_in = 5'd20;
            @(posedge clock); #1;
            n++;
            start = 1'b0;
            while (!done && n < 40) begin @(posedge clock); #1; n++; end
            check("ignore latency", n, 32'd33);
            check("ignore result", result, 32'd54);
            check("ignore rd_out", {27'd0, rd_out}, 32'd0);
            check("rd0 done", {31'd0, done}, 32'd1);
            check("rd0 regwrite", {31'd0, regwrite}, 32'd0);
            @(posedge clock); #1;
            check("ignore idle_after", {31'd0, busy}, 32'd0);
        end

        // Reset mid-DIV aborts with no done pulse, then a fresh op works.
        begin
            int saw_done;
            @(negedge clock);
            start = 1'b1; funct3 = 3'b100; operand_a = 32'd100; operand_b = 32'd7; rd_in = 5'd3;
            @(posedge clock); #1;
            start = 1'b0;
            repeat (14) @(posedge clock);
            @(negedge clock);
            reset = 1'b1;
            @(posedge clock); #1;
            check("abort busy", {31'd0, busy}, 32'd0);
            check("abort done", {31'd0, done}, 32'd0);
            check("abort result", result, 32'd0);
            @(negedge clock);
            reset = 1'b0;
            saw_done = 0;
            repeat (40) begin @(posedge clock); #1; if (done) saw_done = 1; end
            check("abort no_done", saw_done, 32'd0);
            run_op("after_abort", 3'b100, 32'd100, 32'd7, 5'd3, 32'd14);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
